// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } spi_state_t;

  localparam int unsigned RW_BIT    = 7;
  localparam int unsigned ADDR_BITS = 2;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with rise/fall detection on the synchronized value.
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
      q_d  <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      q_d  <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave exposing a four-entry register bank.
// Accepts a command byte, then streams write or read data with an auto-incrementing address.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int unsigned           DATA_BITS = 8,
  parameter logic [DATA_BITS-1:0]  RESET_VAL = '0
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 SCK,
  input  logic                 SS,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 miso_oe,
  output logic                 wr_strobe,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] reg_1_out,
  output logic [DATA_BITS-1:0] reg_2_out,
  output logic [DATA_BITS-1:0] reg_3_out,
  output logic [DATA_BITS-1:0] reg_4_out
);

  localparam int unsigned          CW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0]        LAST_BIT = CW'(DATA_BITS - 1);

  logic sck_sync, sck_rise, sck_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk_in), .rst_n(n_rst), .d(SCK),
    .q(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk_in), .rst_n(n_rst), .d(SS),
    .q(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk_in), .rst_n(n_rst), .d(MOSI),
    .q(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sck_sync, mosi_rise, mosi_fall};

  spi_state_t           state;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] tx_shift;
  logic [ADDR_BITS-1:0] addr;
  logic                 rw;
  logic [DATA_BITS-1:0] bank [4];
  logic [1:0]           settle;
  logic                 armed;

  logic [DATA_BITS-1:0] rx_next;
  logic [ADDR_BITS-1:0] addr_next;

  always_comb begin
    rx_next   = {rx_shift[DATA_BITS-2:0], mosi_sync};
    addr_next = addr + 2'd1;
  end

  // The SS synchronizer resets high, so a low SS held through reset would look
  // like a fresh fall; frames are only accepted after SS has been seen high.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      addr      <= '0;
      rw        <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      settle    <= '0;
      armed     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) bank[i] <= RESET_VAL;
    end else begin
      wr_strobe <= 1'b0;
      settle    <= {settle[0], 1'b1};
      if (settle[1] && ss_sync) armed <= 1'b1;

      if (ss_rise) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall && armed) begin
              state    <= CMD;
              bit_cnt  <= '0;
              rx_shift <= '0;
              tx_shift <= '0;
            end
          end
          CMD, DATA: begin
            if (sck_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                if (state == CMD) begin
                  state    <= DATA;
                  addr     <= rx_next[ADDR_BITS-1:0];
                  rw       <= rx_next[RW_BIT];
                  tx_shift <= rx_next[RW_BIT] ? bank[rx_next[ADDR_BITS-1:0]] : '0;
                end else begin
                  addr <= addr_next;
                  if (rw) begin
                    tx_shift <= bank[addr_next];
                  end else begin
                    bank[addr] <= rx_next;
                    wr_strobe  <= 1'b1;
                    wr_addr    <= addr;
                    tx_shift   <= '0;
                  end
                end
              end
            end else if (sck_fall && bit_cnt != '0) begin
              tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign MISO      = tx_shift[DATA_BITS-1];
  assign miso_oe   = ~ss_sync;
  assign reg_1_out = bank[0];
  assign reg_2_out = bank[1];
  assign reg_3_out = bank[2];
  assign reg_4_out = bank[3];

endmodule
